// File: rtl/memory_stage_pkg.sv
// memory_stage_pkg: shared control-word bit indices, access-size encodings and FSM states
// for the memory stage.
package memory_stage_pkg;

    localparam int CST_REG_WEN = 0;
    localparam int CST_LD      = 1;
    localparam int CST_ST      = 2;
    localparam int CST_W_OP    = 17;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        return sz == 2'd0 ? 8'h01 : sz == 2'd1 ? 8'h03 : sz == 2'd2 ? 8'h0F : 8'hFF;
    endfunction

endpackage

// File: rtl/memory_stage_align.sv
// mem_align: byte-lane steering for stores and alignment plus sign/zero extension for loads.
module mem_align
    import memory_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [2:0]  off,
    input  logic [63:0] sr2,
    input  logic [63:0] rdata,
    output logic [7:0]  wstrb,
    output logic [63:0] wdata,
    output logic [63:0] ld_res,
    output logic        misalign
);

    logic [1:0]  sz;
    logic [63:0] sh;

    always_comb begin
        sz       = funct3[1:0];
        misalign = sz == 2'd1 ? off[0] : sz == 2'd2 ? |off[1:0] : sz == 2'd3 ? |off : 1'b0;
        wstrb    = size_mask(sz) << off;
        wdata    = sr2 << {off, 3'b000};
        sh       = rdata >> {off, 3'b000};
        ld_res   = funct3 == F3_B  ? {{56{sh[7]}}, sh[7:0]} :
                   funct3 == F3_H  ? {{48{sh[15]}}, sh[15:0]} :
                   funct3 == F3_W  ? {{32{sh[31]}}, sh[31:0]} :
                   funct3 == F3_BU ? {56'd0, sh[7:0]} :
                   funct3 == F3_HU ? {48'd0, sh[15:0]} :
                   funct3 == F3_WU ? {32'd0, sh[31:0]} : sh;
    end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: performs load/store accesses over a valid/ready data port and registers
// the writeback latches, stalling upstream while an access is outstanding.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CST_W = 19
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             MEM_V,
    input  logic [CST_W-1:0] MEM_Cst,
    input  logic [XLEN-1:0]  MEM_ALU_RES,
    input  logic [XLEN-1:0]  MEM_SR2,
    input  logic             MEM_PC_MUX,
    input  logic [XLEN-1:0]  MEM_NPC,
    input  logic [31:0]      MEM_IR,
    input  logic [XLEN-1:0]  MEM_Target_Address,
    input  logic             FLUSH,
    output logic             DMEM_REQ_V,
    input  logic             DMEM_REQ_RDY,
    output logic             DMEM_WE,
    output logic [XLEN-1:0]  DMEM_ADDR,
    output logic [XLEN-1:0]  DMEM_WDATA,
    output logic [7:0]       DMEM_WSTRB,
    input  logic             DMEM_RESP_V,
    input  logic [XLEN-1:0]  DMEM_RDATA,
    output logic             MEM_STALL,
    output logic             MEM_MISALIGN,
    output logic             WB_V,
    output logic [CST_W-1:0] WB_Cst,
    output logic [XLEN-1:0]  WB_RES,
    output logic             WB_PC_MUX,
    output logic [XLEN-1:0]  WB_NPC,
    output logic [31:0]      WB_IR,
    output logic [XLEN-1:0]  WB_Target_Address
);

    state_e            state_q, state_d;
    logic              squash_q, squash_d;
    logic              wb_v_q, wb_v_d;
    logic [CST_W-1:0]  wb_cst_q;
    logic [XLEN-1:0]   wb_res_q, wb_res_d, wb_npc_q, wb_tgt_q;
    logic              wb_pc_mux_q;
    logic [31:0]       wb_ir_q;
    logic              ld, st, is_mem, misalign, req_v, stall, mis;
    logic [XLEN-1:0]   ld_res;

    assign ld     = MEM_Cst[CST_LD];
    assign st     = MEM_Cst[CST_ST];
    assign is_mem = ld | st;

    mem_align u_align (
        .funct3   (MEM_IR[14:12]),
        .off      (MEM_ALU_RES[2:0]),
        .sr2      (MEM_SR2),
        .rdata    (DMEM_RDATA),
        .wstrb    (DMEM_WSTRB),
        .wdata    (DMEM_WDATA),
        .ld_res   (ld_res),
        .misalign (misalign)
    );

    always_comb begin
        state_d  = state_q;
        squash_d = squash_q;
        req_v    = 1'b0;
        stall    = 1'b0;
        mis      = 1'b0;
        wb_v_d   = 1'b0;
        wb_res_d = ld ? ld_res : MEM_ALU_RES;
        case (state_q)
            IDLE: if (MEM_V && !FLUSH) begin
                if (!is_mem) wb_v_d = 1'b1;
                else if (misalign) mis = 1'b1;
                else begin
                    req_v   = 1'b1;
                    stall   = 1'b1;
                    state_d = DMEM_REQ_RDY ? RESP : REQ;
                end
            end
            REQ: if (FLUSH) state_d = IDLE;
            else begin
                req_v   = 1'b1;
                stall   = 1'b1;
                state_d = DMEM_REQ_RDY ? RESP : REQ;
            end
            RESP: if (DMEM_RESP_V) begin
                // a squashed access still has to drain its response before retiring
                wb_v_d   = !(squash_q || FLUSH);
                squash_d = 1'b0;
                state_d  = IDLE;
            end else begin
                stall    = 1'b1;
                squash_d = squash_q | FLUSH;
            end
            default: state_d = IDLE;
        endcase
    end

    assign DMEM_REQ_V   = req_v & ~RESET;
    assign MEM_STALL    = stall & ~RESET;
    assign MEM_MISALIGN = mis & ~RESET;
    assign DMEM_WE      = st;
    assign DMEM_ADDR    = {MEM_ALU_RES[XLEN-1:3], 3'b000};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            squash_q    <= 1'b0;
            wb_v_q      <= 1'b0;
            wb_cst_q    <= '0;
            wb_res_q    <= '0;
            wb_pc_mux_q <= 1'b0;
            wb_npc_q    <= '0;
            wb_ir_q     <= '0;
            wb_tgt_q    <= '0;
        end else begin
            state_q     <= state_d;
            squash_q    <= squash_d;
            wb_v_q      <= wb_v_d;
            wb_cst_q    <= MEM_Cst;
            wb_res_q    <= wb_res_d;
            wb_pc_mux_q <= MEM_PC_MUX;
            wb_npc_q    <= MEM_NPC;
            wb_ir_q     <= MEM_IR;
            wb_tgt_q    <= MEM_Target_Address;
        end
    end

    assign WB_V              = wb_v_q;
    assign WB_Cst            = wb_cst_q;
    assign WB_RES            = wb_res_q;
    assign WB_PC_MUX         = wb_pc_mux_q;
    assign WB_NPC            = wb_npc_q;
    assign WB_IR             = wb_ir_q;
    assign WB_Target_Address = wb_tgt_q;

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: scenario tasks driving the memory stage, with a writeback scoreboard
// that checks every WB_V pulse against queued expected results.
module tb_memory_stage;

    logic        CLK = 1'b0, RESET = 1'b1;
    logic        MEM_V = 1'b0, MEM_PC_MUX = 1'b0, FLUSH = 1'b0;
    logic [18:0] MEM_Cst = '0;
    logic [63:0] MEM_ALU_RES = '0, MEM_SR2 = '0, MEM_NPC = '0, MEM_Target_Address = '0;
    logic [31:0] MEM_IR = '0;
    logic        DMEM_REQ_V, DMEM_REQ_RDY = 1'b0, DMEM_WE, DMEM_RESP_V = 1'b0;
    logic [63:0] DMEM_ADDR, DMEM_WDATA, DMEM_RDATA = '0;
    logic [7:0]  DMEM_WSTRB;
    logic        MEM_STALL, MEM_MISALIGN, WB_V, WB_PC_MUX;
    logic [18:0] WB_Cst;
    logic [63:0] WB_RES, WB_NPC, WB_Target_Address;
    logic [31:0] WB_IR;

    int          errors = 0, checks = 0;
    logic [63:0] exp_q[$];
    logic [63:0] sb_exp;

    memory_stage dut (
        .CLK(CLK), .RESET(RESET), .MEM_V(MEM_V), .MEM_Cst(MEM_Cst), .MEM_ALU_RES(MEM_ALU_RES),
        .MEM_SR2(MEM_SR2), .MEM_PC_MUX(MEM_PC_MUX), .MEM_NPC(MEM_NPC), .MEM_IR(MEM_IR),
        .MEM_Target_Address(MEM_Target_Address), .FLUSH(FLUSH), .DMEM_REQ_V(DMEM_REQ_V),
        .DMEM_REQ_RDY(DMEM_REQ_RDY), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR),
        .DMEM_WDATA(DMEM_WDATA), .DMEM_WSTRB(DMEM_WSTRB), .DMEM_RESP_V(DMEM_RESP_V),
        .DMEM_RDATA(DMEM_RDATA), .MEM_STALL(MEM_STALL), .MEM_MISALIGN(MEM_MISALIGN),
        .WB_V(WB_V), .WB_Cst(WB_Cst), .WB_RES(WB_RES), .WB_PC_MUX(WB_PC_MUX), .WB_NPC(WB_NPC),
        .WB_IR(WB_IR), .WB_Target_Address(WB_Target_Address)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (WB_V === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: WB_V=1 WB_RES=%h, required no writeback", WB_RES);
            end else begin
                sb_exp = exp_q.pop_front();
                if (WB_RES !== sb_exp) begin
                    errors++;
                    $display("FAIL wb_res: got %h, required %h", WB_RES, sb_exp);
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [18:0] cst, input logic [63:0] addr, input logic [63:0] sr2,
                         input logic [2:0] f3);
        MEM_V       = 1'b1;
        MEM_Cst     = cst;
        MEM_ALU_RES = addr;
        MEM_SR2     = sr2;
        MEM_IR      = {17'd0, f3, 12'h003};
        MEM_NPC     = addr + 64'd4;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({WB_V, DMEM_REQ_V, MEM_STALL, MEM_MISALIGN} !== 4'b0 || WB_RES !== 64'd0) begin
            errors++;
            $display("FAIL reset: v/req/stall/mis=%b%b%b%b res=%h, required 0000 0",
                     WB_V, DMEM_REQ_V, MEM_STALL, MEM_MISALIGN, WB_RES);
        end
        step();
        step();
        RESET = 1'b0;
    endtask

    task automatic test_alu();
        issue(19'h1, 64'h1234, 64'd0, 3'b000);
        exp_q.push_back(64'h1234);
        @(negedge CLK);
        checks++;
        if (MEM_STALL !== 1'b0 || DMEM_REQ_V !== 1'b0) begin
            errors++;
            $display("FAIL alu_nostall: stall=%b req=%b, required 0 0", MEM_STALL, DMEM_REQ_V);
        end
        step();
        MEM_V = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        issue(19'h1, 64'hAAAA, 64'd0, 3'b000);
        exp_q.push_back(64'hAAAA);
        step();
        issue(19'h1, 64'h5555_0000_0000_0001, 64'd0, 3'b000);
        exp_q.push_back(64'h5555_0000_0000_0001);
        step();
        MEM_V = 1'b0;
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: %0d results outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_load(input logic [2:0] f3, input logic [63:0] exp);
        issue(19'h3, 64'h1003, 64'd0, f3);
        DMEM_REQ_RDY = 1'b1;
        @(negedge CLK);
        checks++;
        if (DMEM_REQ_V !== 1'b1 || DMEM_ADDR !== 64'h1000 || DMEM_WE !== 1'b0 || MEM_STALL !== 1'b1) begin
            errors++;
            $display("FAIL load_req: req=%b addr=%h we=%b stall=%b, required 1 1000 0 1",
                     DMEM_REQ_V, DMEM_ADDR, DMEM_WE, MEM_STALL);
        end
        step();
        DMEM_REQ_RDY = 1'b0;
        DMEM_RESP_V  = 1'b1;
        DMEM_RDATA   = 64'h0000_0000_8000_0000;
        exp_q.push_back(exp);
        @(negedge CLK);
        checks++;
        if (MEM_STALL !== 1'b0 || DMEM_REQ_V !== 1'b0) begin
            errors++;
            $display("FAIL load_resp_stall: stall=%b req=%b, required 0 0", MEM_STALL, DMEM_REQ_V);
        end
        step();
        MEM_V       = 1'b0;
        DMEM_RESP_V = 1'b0;
        step();
    endtask

    task automatic test_store_wait();
        issue(19'h4, 64'h2006, 64'hBEEF, 3'b001);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++;
            if (DMEM_REQ_V !== 1'b1 || DMEM_WE !== 1'b1 || DMEM_ADDR !== 64'h2000 ||
                DMEM_WSTRB !== 8'hC0 || DMEM_WDATA !== 64'hBEEF_0000_0000_0000 || MEM_STALL !== 1'b1) begin
                errors++;
                $display("FAIL sh_hold[%0d]: req=%b we=%b addr=%h strb=%h wdata=%h stall=%b, required 1 1 2000 c0 beef000000000000 1",
                         i, DMEM_REQ_V, DMEM_WE, DMEM_ADDR, DMEM_WSTRB, DMEM_WDATA, MEM_STALL);
            end
            step();
        end
        DMEM_REQ_RDY = 1'b1;
        step();
        DMEM_REQ_RDY = 1'b0;
        @(negedge CLK);
        checks++;
        if (MEM_STALL !== 1'b1 || DMEM_REQ_V !== 1'b0) begin
            errors++;
            $display("FAIL sh_wait_resp: stall=%b req=%b, required 1 0", MEM_STALL, DMEM_REQ_V);
        end
        step();
        DMEM_RESP_V = 1'b1;
        exp_q.push_back(64'h2006);
        step();
        MEM_V       = 1'b0;
        DMEM_RESP_V = 1'b0;
        step();
    endtask

    task automatic test_misalign();
        issue(19'h3, 64'h3002, 64'd0, 3'b010);
        @(negedge CLK);
        checks++;
        if (DMEM_REQ_V !== 1'b0 || MEM_MISALIGN !== 1'b1 || MEM_STALL !== 1'b0) begin
            errors++;
            $display("FAIL misalign: req=%b mis=%b stall=%b, required 0 1 0", DMEM_REQ_V, MEM_MISALIGN, MEM_STALL);
        end
        step();
        MEM_V = 1'b0;
        @(negedge CLK);
        checks++;
        if (MEM_MISALIGN !== 1'b0 || WB_V !== 1'b0) begin
            errors++;
            $display("FAIL misalign_pulse: mis=%b wb_v=%b, required 0 0", MEM_MISALIGN, WB_V);
        end
        step();
    endtask

    task automatic test_flush_req();
        issue(19'h3, 64'h1000, 64'd0, 3'b000);
        step();
        FLUSH = 1'b1;
        @(negedge CLK);
        checks++;
        if (DMEM_REQ_V !== 1'b0 || MEM_STALL !== 1'b0) begin
            errors++;
            $display("FAIL flush_req: req=%b stall=%b, required 0 0", DMEM_REQ_V, MEM_STALL);
        end
        step();
        FLUSH = 1'b0;
        MEM_V = 1'b0;
        @(negedge CLK);
        checks++;
        if (WB_V !== 1'b0 || DMEM_REQ_V !== 1'b0) begin
            errors++;
            $display("FAIL flush_req_wb: wb_v=%b req=%b, required 0 0", WB_V, DMEM_REQ_V);
        end
        step();
    endtask

    task automatic test_flush_resp();
        issue(19'h3, 64'h4000, 64'd0, 3'b011);
        DMEM_REQ_RDY = 1'b1;
        step();
        DMEM_REQ_RDY = 1'b0;
        FLUSH        = 1'b1;
        @(negedge CLK);
        checks++;
        if (MEM_STALL !== 1'b1) begin
            errors++;
            $display("FAIL flush_resp_stall0: stall=%b, required 1", MEM_STALL);
        end
        step();
        FLUSH = 1'b0;
        @(negedge CLK);
        checks++;
        if (MEM_STALL !== 1'b1 || DMEM_REQ_V !== 1'b0) begin
            errors++;
            $display("FAIL flush_resp_stall1: stall=%b req=%b, required 1 0", MEM_STALL, DMEM_REQ_V);
        end
        step();
        DMEM_RESP_V = 1'b1;
        DMEM_RDATA  = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge CLK);
        checks++;
        if (MEM_STALL !== 1'b0) begin
            errors++;
            $display("FAIL flush_resp_release: stall=%b, required 0", MEM_STALL);
        end
        step();
        DMEM_RESP_V = 1'b0;
        MEM_V       = 1'b0;
        @(negedge CLK);
        checks++;
        if (WB_V !== 1'b0) begin
            errors++;
            $display("FAIL flush_resp_wb: wb_v=%b, required 0", WB_V);
        end
        issue(19'h1, 64'h77, 64'd0, 3'b000);
        exp_q.push_back(64'h77);
        step();
        MEM_V = 1'b0;
        step();
    endtask

    task automatic test_flush_with_resp();
        issue(19'h4, 64'h6000, 64'h1, 3'b011);
        DMEM_REQ_RDY = 1'b1;
        step();
        DMEM_REQ_RDY = 1'b0;
        DMEM_RESP_V  = 1'b1;
        FLUSH        = 1'b1;
        step();
        DMEM_RESP_V = 1'b0;
        FLUSH       = 1'b0;
        MEM_V       = 1'b0;
        @(negedge CLK);
        checks++;
        if (WB_V !== 1'b0 || MEM_STALL !== 1'b0) begin
            errors++;
            $display("FAIL flush_coincident: wb_v=%b stall=%b, required 0 0", WB_V, MEM_STALL);
        end
        step();
    endtask

    task automatic test_reset_mid_resp();
        issue(19'h3, 64'h5008, 64'd0, 3'b011);
        DMEM_REQ_RDY = 1'b1;
        step();
        DMEM_REQ_RDY = 1'b0;
        #1;
        RESET = 1'b1;
        #1;
        checks++;
        if (DMEM_REQ_V !== 1'b0 || MEM_STALL !== 1'b0 || WB_V !== 1'b0 || WB_RES !== 64'd0) begin
            errors++;
            $display("FAIL reset_async: req=%b stall=%b wb_v=%b res=%h, required 0 0 0 0",
                     DMEM_REQ_V, MEM_STALL, WB_V, WB_RES);
        end
        step();
        RESET        = 1'b0;
        DMEM_REQ_RDY = 1'b1;
        @(negedge CLK);
        checks++;
        if (DMEM_REQ_V !== 1'b1 || DMEM_ADDR !== 64'h5008 || MEM_STALL !== 1'b1) begin
            errors++;
            $display("FAIL reset_reissue: req=%b addr=%h stall=%b, required 1 5008 1", DMEM_REQ_V, DMEM_ADDR, MEM_STALL);
        end
        step();
        DMEM_REQ_RDY = 1'b0;
        DMEM_RESP_V  = 1'b1;
        DMEM_RDATA   = 64'h1122_3344_5566_7788;
        exp_q.push_back(64'h1122_3344_5566_7788);
        step();
        DMEM_RESP_V = 1'b0;
        MEM_V       = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        step();
        test_alu();
        test_back_to_back();
        test_load(3'b000, 64'hFFFF_FFFF_FFFF_FF80);
        test_load(3'b100, 64'h0000_0000_0000_0080);
        test_store_wait();
        test_misalign();
        test_flush_req();
        test_flush_resp();
        test_flush_with_resp();
        test_reset_mid_resp();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results never written back, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
